// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first) feeding a circular receive FIFO.
// Bytes are pushed on the edge that samples the stop bit and popped one per rd strobe.
module uart_rx_fifo #(
  parameter int clk_freq   = 50000000,
  parameter int baud       = 115200,
  parameter int depth_log2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rxd,
  input  logic                rd,
  output logic [7:0]          drec,
  output logic                empty,
  output logic                full,
  output logic [depth_log2:0] count,
  output logic                frame_err,
  output logic                overrun
);

  localparam int DIV   = clk_freq / baud;
  localparam int CW    = $clog2(DIV);
  localparam int DEPTH = 2 ** depth_log2;
  localparam logic [CW-1:0]         HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0]         FULL_M1 = CW'(DIV - 1);
  localparam logic [depth_log2:0]   DEPTH_C = (depth_log2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic       rx_meta_q, rxs_q, rxs_prev_q;
  logic [1:0] flush_q;
  logic       armed_q;
  logic       start_edge;

  // The synchroniser reset value is not the line; arm only once rxs has seen a genuine idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      flush_q    <= 2'd0;
      armed_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep each flop sampling the pre-edge value of its neighbour.
      rx_meta_q  <= rxd;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      if (flush_q != 2'd3) flush_q <= flush_q + 2'd1;
      if (flush_q == 2'd3 && rxs_q) armed_q <= 1'b1;
    end
  end

  assign start_edge = armed_q && rxs_prev_q && !rxs_q;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push, bad_stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_edge) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs_q;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    bad_stop = 1'b0;
    if (state_q == STOP && cnt_q == FULL_M1) begin
      push     = rxs_q;
      bad_stop = !rxs_q;
    end
  end

  logic [7:0]            mem [DEPTH];
  logic [depth_log2-1:0] wptr_q, rptr_q;
  logic [depth_log2:0]   count_q;
  logic [7:0]            drec_q;
  logic                  frame_err_q, overrun_q;
  logic                  pop, is_full, push_ok;

  assign pop     = rd && (count_q != '0);
  assign is_full = (count_q == DEPTH_C);
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!is_full || pop);

  // NOTE: the storage array has no reset; count and the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      drec_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        drec_q <= mem[rptr_q];
      end
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      frame_err_q <= bad_stop;
      overrun_q   <= push && is_full && !pop;
    end
  end

  assign drec      = drec_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = is_full;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 50 MHz / 921600 baud (DIV = 54, truncated from 54.25).
// Frames are driven on falling clock edges; outputs are sampled on falling edges.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 921_600;
  localparam int DIV      = 54;
  localparam int FRAME    = 10 * DIV;
  // Start fall at frame step 0: 2 sync flops + 1 edge register, half bit, then 9 full bits.
  localparam int PUSH_K   = 3 + DIV / 2 + 9 * DIV;

  logic       clk = 1'b0;
  logic       rst, rxd, rd;
  logic [7:0] drec;
  logic       empty, full;
  logic [4:0] count;
  logic       frame_err, overrun;

  int n_vec = 0;
  int n_err = 0;
  int fe_n, ov_n, fe_k, ov_k, c_pre, c_post;
  logic [7:0] popped [16];

  uart_rx_fifo #(
    .clk_freq  (CLK_FREQ),
    .baud      (BAUD),
    .depth_log2(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rd       (rd),
    .drec     (drec),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #10 clk = ~clk;

  task automatic clear_stats();
    fe_n = 0; ov_n = 0; fe_k = -1; ov_k = -1; c_pre = -1; c_post = -1;
  endtask

  task automatic sample_pulses(input int k);
    if (frame_err) begin
      fe_n++;
      if (fe_k < 0) fe_k = k;
    end
    if (overrun) begin
      ov_n++;
      if (ov_k < 0) ov_k = k;
    end
  endtask

  task automatic hold_line(input logic lvl, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rxd = lvl;
      rd  = 1'b0;
      sample_pulses(-2);
    end
  endtask

  // Drives n_k steps of a frame; rd pulses for one cycle at step rd_at.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int rd_at,
                            input int n_k);
    for (int k = 0; k < n_k; k++) begin
      int idx;
      @(negedge clk);
      idx = k / DIV;
      if (idx == 0)      rxd = 1'b0;
      else if (idx == 9) rxd = stop_bit;
      else               rxd = d[idx-1];
      rd = (k == rd_at);
      sample_pulses(k);
      if (k == PUSH_K - 1) c_pre  = int'(count);
      if (k == PUSH_K)     c_post = int'(count);
    end
    rd = 1'b0;
  endtask

  task automatic pop_burst(input int n);
    @(negedge clk);
    rd = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      popped[i] = drec;
      if (i == n - 1) rd = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; rd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_stats();
    hold_line(1'b1, 20);
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (drec !== 8'h00) begin n_err++; $display("FAIL reset_drec: got %h want 00", drec); end
    n_vec++; if (fe_n + ov_n != 0) begin n_err++; $display("FAIL reset_pulses: got %0d want 0", fe_n + ov_n); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    exp[0] = 8'h05; exp[1] = 8'h0A; exp[2] = 8'h0F; exp[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      clear_stats();
      send_frame(exp[i], 1'b1, -1, FRAME);
      n_vec++; if (c_pre != i) begin n_err++; $display("FAIL b2b_count_pre[%0d]: got %0d want %0d", i, c_pre, i); end
      n_vec++; if (c_post != i + 1) begin n_err++; $display("FAIL b2b_count_post[%0d]: got %0d want %0d", i, c_post, i + 1); end
      n_vec++; if (fe_n != 0) begin n_err++; $display("FAIL b2b_frame_err[%0d]: got %0d want 0", i, fe_n); end
    end
    pop_burst(4);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (popped[i] !== exp[i]) begin n_err++; $display("FAIL b2b_drec[%0d]: got %h want %h", i, popped[i], exp[i]); end
    end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", empty); end
  endtask

  task automatic test_glitch();
    clear_stats();
    hold_line(1'b1, 5);
    hold_line(1'b0, 10);
    hold_line(1'b1, 3 * DIV);
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL glitch_count: got %0d want 0", count); end
    n_vec++; if (fe_n != 0) begin n_err++; $display("FAIL glitch_frame_err: got %0d want 0", fe_n); end
    clear_stats();
    send_frame(8'h55, 1'b1, -1, FRAME);
    n_vec++; if (c_post != 1) begin n_err++; $display("FAIL glitch_next_count: got %0d want 1", c_post); end
    pop_burst(1);
    n_vec++; if (popped[0] !== 8'h55) begin n_err++; $display("FAIL glitch_next_drec: got %h want 55", popped[0]); end
  endtask

  task automatic test_frame_error();
    clear_stats();
    send_frame(8'hA5, 1'b0, -1, FRAME);
    n_vec++; if (fe_n != 1) begin n_err++; $display("FAIL ferr_pulses: got %0d want 1", fe_n); end
    n_vec++; if (fe_k != PUSH_K) begin n_err++; $display("FAIL ferr_timing: got %0d want %0d", fe_k, PUSH_K); end
    n_vec++; if (c_post != 0) begin n_err++; $display("FAIL ferr_count: got %0d want 0", c_post); end
    hold_line(1'b1, DIV);
    clear_stats();
    send_frame(8'h3C, 1'b1, -1, FRAME);
    n_vec++; if (c_post != 1 || fe_n != 0) begin n_err++; $display("FAIL ferr_next: count %0d ferr %0d want 1 0", c_post, fe_n); end
    pop_burst(1);
    n_vec++; if (popped[0] !== 8'h3C) begin n_err++; $display("FAIL ferr_next_drec: got %h want 3C", popped[0]); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) begin
      clear_stats();
      send_frame(8'(i), 1'b1, -1, FRAME);
      if (i == 14) begin
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL ovr_full_at_15: got %b want 0", full); end
      end
    end
    n_vec++; if (full !== 1'b1 || count !== 5'd16) begin n_err++; $display("FAIL ovr_full: full %b count %0d want 1 16", full, count); end
    clear_stats();
    send_frame(8'h10, 1'b1, -1, FRAME);
    n_vec++; if (ov_n != 1) begin n_err++; $display("FAIL ovr_pulses: got %0d want 1", ov_n); end
    n_vec++; if (ov_k != PUSH_K) begin n_err++; $display("FAIL ovr_timing: got %0d want %0d", ov_k, PUSH_K); end
    n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL ovr_count: got %0d want 16", count); end
    pop_burst(16);
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (popped[i] !== 8'(i)) begin n_err++; $display("FAIL ovr_drec[%0d]: got %h want %h", i, popped[i], 8'(i)); end
    end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovr_empty: got %b want 1", empty); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] want;
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1, -1, FRAME);
    clear_stats();
    send_frame(8'h30, 1'b1, PUSH_K - 1, FRAME);
    n_vec++; if (ov_n != 0) begin n_err++; $display("FAIL pp_overrun: got %0d want 0", ov_n); end
    n_vec++; if (c_pre != 16 || c_post != 16) begin n_err++; $display("FAIL pp_count: pre %0d post %0d want 16 16", c_pre, c_post); end
    n_vec++; if (drec !== 8'h20) begin n_err++; $display("FAIL pp_drec: got %h want 20", drec); end
    pop_burst(16);
    for (int i = 0; i < 16; i++) begin
      want = (i < 15) ? 8'h21 + 8'(i) : 8'h30;
      n_vec++; if (popped[i] !== want) begin n_err++; $display("FAIL pp_drain[%0d]: got %h want %h", i, popped[i], want); end
    end
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    n_vec++; if (drec !== 8'h30 || count !== 5'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL pp_empty_rd: drec %h count %0d empty %b want 30 0 1", drec, count, empty);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_stats();
    send_frame(8'h77, 1'b1, -1, FRAME);
    n_vec++; if (c_post != 1) begin n_err++; $display("FAIL rst_pre_count: got %0d want 1", c_post); end
    send_frame(8'h99, 1'b1, -1, 130);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_vec++; if (drec !== 8'h00 || count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_err++; $display("FAIL rst_outputs: drec %h count %0d empty %b full %b want 00 0 1 0", drec, count, empty, full);
    end
    clear_stats();
    hold_line(1'b0, 30);
    hold_line(1'b1, 2 * FRAME);
    n_vec++; if (count !== 5'd0 || fe_n != 0 || ov_n != 0) begin
      n_err++; $display("FAIL rst_discard: count %0d ferr %0d ovr %0d want 0 0 0", count, fe_n, ov_n);
    end
    clear_stats();
    send_frame(8'h42, 1'b1, -1, FRAME);
    pop_burst(1);
    n_vec++; if (popped[0] !== 8'h42) begin n_err++; $display("FAIL rst_recover: got %h want 42", popped[0]); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_push_pop_full();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial UART receiver (8N1, LSB first) with a receive FIFO.
- Sits on the receive end of the `system` UART link, paired with the existing transmit path.
- Deserialises the `rxd` line and buffers complete bytes.
- Presents bytes on `drec` one at a time, each under a single-cycle `rd` strobe from the host logic.

Parameters:
- clk_freq, 50000000, system clock frequency in Hz.
- baud, 115200, line rate in bit/s. Bit period DIV = clk_freq/baud clocks, integer-truncated. DIV must be at least 4.
- depth_log2, 4, FIFO depth is 2**depth_log2 entries, so 16 by default.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rxd  in  1  asynchronous serial input; idles high.
- rd  in  1  read strobe; pops one byte from the FIFO.
- drec  out  8  last byte popped (registered).
- empty  out  1  FIFO holds no bytes.
- full  out  1  FIFO holds 2**depth_log2 bytes.
- count  out  depth_log2+1  number of bytes currently held.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte received while full with no simultaneous pop; the byte is lost.

Behaviour:
- Reset values: drec=0, empty=1, full=0, count=0, frame_err=0, overrun=0; FSM=IDLE; pointers, bit counter and baud counter = 0; synchroniser flops = 1.
- rst has priority over everything and aborts any frame in progress. If rxd is low when reset is released, IDLE waits for rxd high before it will arm.
- Synchroniser: rxd passes through 2 flops (rxs). All edge detection and sampling use rxs.
- IDLE:
  - Falling edge on rxs (previous 1, current 0) → START, baud counter = 0.
- START:
  - When the counter reaches DIV/2-1: if rxs=0 → DATA, counter = 0, bit index = 0.
  - If rxs=1, it is a glitch → IDLE.
- DATA:
  - When the counter reaches DIV-1, which is mid-bit, sample rxs into shift[bit index]. Counter = 0, bit index +1.
  - After bit 7 → STOP.
- STOP:
  - When the counter reaches DIV-1, sample rxs.
  - rxs=1: push the byte; overrun if rejected.
  - rxs=0: pulse frame_err for 1 cycle, discard the byte.
  - In both cases → IDLE. A new start edge is accepted from the next cycle.
- Push timing: the byte is written on the same clock edge that samples the stop bit. empty deasserts and count increments in that same cycle.
- FIFO is a circular buffer of 2**depth_log2 x 8. Write and read pointers are depth_log2 bits wide and wrap naturally.
- count is the source of truth:
  - full = (count == 2**depth_log2)
  - empty = (count == 0)
- Pop:
  - rd=1 and empty=0: drec <= mem[rptr], rptr+1, count-1. drec is valid on the cycle after rd.
  - rd=1 and empty=1: ignored; drec holds, nothing changes.
- Push while not full: write, wptr+1, count+1.
- Push while full and rd=0: byte dropped, overrun pulses 1 cycle, contents unchanged.
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - This applies even when full: the pop frees the slot and the push succeeds with no overrun.
  - When empty, the pop is ignored (empty rule) and the push succeeds; count becomes 1.
- rd held high for N cycles pops up to N bytes, one per cycle.
- Frame timing: the full frame is about 9.5*DIV clocks from start edge to push. Back-to-back frames with a 1-bit stop are received without loss.

Test Plan:
1. Reset, rxd idle high, 20 cycles → empty=1, full=0, count=0, drec=0, no pulses.
2. Serialise bytes 0x05, 0x0A, 0x0F, 0xFF back-to-back (clk_freq=50e6, baud=115200, DIV=434) → count steps 1..4, one step per stop bit. Then pulse rd 4 times, 20 ns apart → drec = 0x05, 0x0A, 0x0F, 0xFF, each one cycle after its rd. empty=1 after the 4th.
3. 200 ns low glitch on rxd while IDLE → returns to IDLE. Count stays 0, no frame_err. A following valid 0x55 frame is received correctly.
4. Frame 0xA5 with stop bit driven low → frame_err one-cycle pulse, count unchanged. The next valid frame 0x3C is pushed.
5. Send 17 bytes 0x00..0x10 with no reads → full=1 after the 16th. On the 17th: overrun pulses once, count=16. Reading 16 times yields 0x00..0x0F; 0x10 is lost.
6. With the FIFO full, assert rd on the exact cycle of a stop-bit push → no overrun, count stays 16, drec = oldest byte. Also assert rd with empty=1 → drec unchanged. Assert rst mid-frame → all outputs at reset values, partial byte discarded.
